ren_map_stage: RTL and testbench
================================

Name: ren_map_stage

Overview:
Rename stage directly upstream of the issue block: maps architectural register specifiers from decode to physical registers. Allocates destination physical registers from a free list and ROB pointers from a wrapping counter. Pushes one renamed instruction per cycle into either the IQ or the LSQ push port. Stalls decode on resource exhaustion.

Parameters:
PAYLOAD_WIDTH, 64, opaque decode payload carried through unchanged (instr word, ALU control, imm, branch/mem flags)
PHYS_REGS, 64, physical register count; ids are 6 bits
ARCH_REGS, 32, architectural register count; ids are 5 bits
ROB_PTR_BITS, 6, ROB pointer width

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-low reset
FREEZE  in  1  global stall; no accept, no push
ID_valid_IN  in  1  decode presents an instruction
ID_src1_IN  in  5  arch src1
ID_src2_IN  in  5  arch src2
ID_dest_IN  in  5  arch dest
ID_needDest_IN  in  1  instruction writes a dest
ID_isMem_IN  in  1  1=LSQ, 0=IQ
ID_payload_IN  in  PAYLOAD_WIDTH  pass-through data
ID_stall_OUT  out  1  combinational; decode must hold its inputs
IQ_full_IN  in  1  IQ full flag
LSQ_full_IN  in  1  LSQ full flag
ROB_full_IN  in  1  ROB cannot accept
RET_freeReq_IN  in  1  retire returns a phys reg
RET_freeReg_IN  in  6  phys reg to free
IQ_pushReq_OUT  out  1  one-cycle push pulse to IQ
LSQ_pushReq_OUT  out  1  one-cycle push pulse to LSQ
REN_pushData_OUT  out  PAYLOAD_WIDTH+31  {payload, robPtr[5:0], oldDest[5:0], dest[5:0], src2[5:0], src1[5:0], needDest}
FL_overflow_OUT  out  1  sticky error: free into full free list

Behaviour:
- Clocking and reset: single clock; reset is synchronous, active-low on RESET, sampled at posedge CLK.
- Reset values:
  - Map table is identity (arch i -> phys i).
  - Free list FIFO holds phys 32..63 in order, head=0, count=32.
  - ROB counter = 0.
  - IQ_pushReq_OUT=0, LSQ_pushReq_OUT=0, REN_pushData_OUT=0, FL_overflow_OUT=0.
  - Reset overrides every other input in the same cycle.
- Effective dest: effNeed = ID_needDest_IN && (ID_dest_IN != 0). Arch r0 is never renamed and always reads phys 0.
- Stall condition: ID_stall_OUT = FREEZE | ROB_full_IN | (effNeed && count==0) | target-queue full | (push to the same queue registered this cycle).
  - Target queue is LSQ if ID_isMem_IN, else IQ.
  - The last term is a conservative guard against the one-cycle full-flag lag.
- Accept: accept = ID_valid_IN && !ID_stall_OUT.
- On accept at edge N:
  - src1/src2 are read from the map table before this instruction's dest write, so srcX==dest yields the old mapping.
  - If effNeed: pop the free-list head into dest; oldDest = map[dest]; map[dest] <= new phys.
  - If !effNeed: dest=0, oldDest=0, map unchanged, no pop.
  - robPtr = ROB counter; counter increments mod 2^ROB_PTR_BITS, wrapping 63->0.
  - Output register is loaded. Exactly one of IQ_pushReq_OUT/LSQ_pushReq_OUT is 1 during cycle N+1, so latency is 1 cycle.
- No accept: both push outputs are 0 next cycle; REN_pushData_OUT holds its last value.
- Free list:
  - Circular FIFO, depth 32.
  - RET_freeReq_IN pushes RET_freeReg_IN at the tail.
  - Simultaneous pop and push in one cycle is legal; count unchanged.
  - No bypass: at count==0, a same-cycle free does not satisfy a pop, so the instruction stalls one cycle.
  - Free at count==32 with no same-cycle pop: the entry is dropped and FL_overflow_OUT is set until reset.
- FREEZE: free-list pushes from retire are still accepted; no rename state otherwise changes.

Test Plan:
- Reset, then accept dest=r5, src1=r5, src2=r3, IQ -> next cycle IQ_pushReq_OUT=1, src1=5, src2=3, dest=32, oldDest=5, robPtr=0; a following read of r5 yields 32.
- 32 back-to-back dest-writing instrs with no frees -> dests 32..63 in order; 33rd gets ID_stall_OUT=1. A free of phys 7 that cycle -> still stalled; accepted next cycle with dest=7.
- dest=r0, needDest=1, mem -> LSQ_pushReq_OUT=1, dest=0, oldDest=0, free-list count unchanged.
- LSQ_full_IN=1 with mem instr -> stall, no push. Same cycle an ALU instr with IQ_full_IN=0 is accepted in place of it -> IQ push; ROB counter advances by 1 only.
- 65 accepted instrs -> robPtr sequence 0..63 then 0.
- Free at count==32 -> FL_overflow_OUT=1 and stays 1 until RESET=0. Mid-stream RESET=0 -> push outputs 0 next cycle, map identity, count=32.

Source files
------------

// File: rtl/ren_map_stage.sv
// ren_map_stage: rename stage mapping arch regs to phys regs, feeding IQ/LSQ
// Ports: CLK/RESET (sync, active-low); FREEZE global stall; ID_* decode inputs
// and ID_stall_OUT back-pressure; IQ/LSQ/ROB full flags; RET_free* returns a
// phys reg to the free list; IQ/LSQ_pushReq_OUT + REN_pushData_OUT registered
// push; FL_overflow_OUT sticky free-into-full error.
module ren_map_stage #(
  parameter int PAYLOAD_WIDTH = 64,
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int ROB_PTR_BITS = 6,
  localparam int PW = $clog2(PHYS_REGS),
  localparam int AW = $clog2(ARCH_REGS),
  localparam int DW = PAYLOAD_WIDTH + ROB_PTR_BITS + 4 * PW + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FREEZE,
  input  logic                     ID_valid_IN,
  input  logic [AW-1:0]            ID_src1_IN,
  input  logic [AW-1:0]            ID_src2_IN,
  input  logic [AW-1:0]            ID_dest_IN,
  input  logic                     ID_needDest_IN,
  input  logic                     ID_isMem_IN,
  input  logic [PAYLOAD_WIDTH-1:0] ID_payload_IN,
  output logic                     ID_stall_OUT,
  input  logic                     IQ_full_IN,
  input  logic                     LSQ_full_IN,
  input  logic                     ROB_full_IN,
  input  logic                     RET_freeReq_IN,
  input  logic [PW-1:0]            RET_freeReg_IN,
  output logic                     IQ_pushReq_OUT,
  output logic                     LSQ_pushReq_OUT,
  output logic [DW-1:0]            REN_pushData_OUT,
  output logic                     FL_overflow_OUT
);
  localparam int FD = PHYS_REGS - ARCH_REGS;
  localparam int FAW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  logic [PW-1:0] map_q [ARCH_REGS];
  logic [PW-1:0] fl_q [FD];
  logic [FAW-1:0] head_q, tail;
  logic [CW-1:0] count_q, count_d;
  logic [ROB_PTR_BITS-1:0] rob_q;
  logic iq_q, lsq_q, ovf_q;
  logic [DW-1:0] data_q;
  logic eff, acc, pop, push, full, qbusy;
  logic [PW-1:0] new_p, old_p;
  always_comb begin
    eff = ID_needDest_IN && (ID_dest_IN != '0);
    // Same-queue push last cycle stalls: the full flag lags our push by one cycle.
    qbusy = ID_isMem_IN ? (LSQ_full_IN || lsq_q) : (IQ_full_IN || iq_q);
    ID_stall_OUT = FREEZE || ROB_full_IN || (eff && count_q == '0) || qbusy;
    acc = ID_valid_IN && !ID_stall_OUT;
    pop = acc && eff;
    full = count_q == CW'(FD);
    // When full, a same-cycle pop frees the head slot, which is exactly the tail.
    push = RET_freeReq_IN && (!full || pop);
    tail = head_q + count_q[FAW-1:0];
    count_d = count_q + CW'(push) - CW'(pop);
    new_p = eff ? fl_q[head_q] : '0;
    old_p = eff ? map_q[ID_dest_IN] : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < FD; i++) fl_q[i] <= PW'(ARCH_REGS + i);
      head_q <= '0;
      count_q <= CW'(FD);
      rob_q <= '0;
      iq_q <= 1'b0;
      lsq_q <= 1'b0;
      data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) fl_q[tail] <= RET_freeReg_IN;
      if (pop) begin
        map_q[ID_dest_IN] <= new_p;
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
      if (RET_freeReq_IN && full && !pop) ovf_q <= 1'b1;
      iq_q <= acc && !ID_isMem_IN;
      lsq_q <= acc && ID_isMem_IN;
      if (acc) begin
        data_q <= {ID_payload_IN, rob_q, old_p, new_p, map_q[ID_src2_IN], map_q[ID_src1_IN], eff};
        rob_q <= rob_q + 1'b1;
      end
    end
  end
  assign IQ_pushReq_OUT = iq_q;
  assign LSQ_pushReq_OUT = lsq_q;
  assign REN_pushData_OUT = data_q;
  assign FL_overflow_OUT = ovf_q;
endmodule

// File: tb/tb_ren_map_stage.sv
// tb_ren_map_stage: randomized + directed check of ren_map_stage against a queue-based model
module tb_ren_map_stage;
  logic CLK = 0, RESET, FREEZE, ID_valid_IN, ID_needDest_IN, ID_isMem_IN;
  logic [4:0] ID_src1_IN, ID_src2_IN, ID_dest_IN;
  logic [63:0] ID_payload_IN;
  logic ID_stall_OUT, IQ_full_IN, LSQ_full_IN, ROB_full_IN, RET_freeReq_IN;
  logic [5:0] RET_freeReg_IN;
  logic IQ_pushReq_OUT, LSQ_pushReq_OUT, FL_overflow_OUT;
  logic [94:0] REN_pushData_OUT;
  int total = 0, bad = 0;
  int mmap [32];
  int fl [$];
  int mrob;
  bit miq, mlsq, movf;
  logic [94:0] mdata;
  ren_map_stage dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .ID_valid_IN(ID_valid_IN),
    .ID_src1_IN(ID_src1_IN), .ID_src2_IN(ID_src2_IN), .ID_dest_IN(ID_dest_IN),
    .ID_needDest_IN(ID_needDest_IN), .ID_isMem_IN(ID_isMem_IN), .ID_payload_IN(ID_payload_IN),
    .ID_stall_OUT(ID_stall_OUT), .IQ_full_IN(IQ_full_IN), .LSQ_full_IN(LSQ_full_IN),
    .ROB_full_IN(ROB_full_IN), .RET_freeReq_IN(RET_freeReq_IN), .RET_freeReg_IN(RET_freeReg_IN),
    .IQ_pushReq_OUT(IQ_pushReq_OUT), .LSQ_pushReq_OUT(LSQ_pushReq_OUT),
    .REN_pushData_OUT(REN_pushData_OUT), .FL_overflow_OUT(FL_overflow_OUT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 32; i++) mmap[i] = i;
    fl = {};
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    mrob = 0; miq = 0; mlsq = 0; movf = 0; mdata = '0;
  endtask
  task automatic idle();
    FREEZE = 0; ID_valid_IN = 0; ID_src1_IN = 0; ID_src2_IN = 0; ID_dest_IN = 0;
    ID_needDest_IN = 0; ID_isMem_IN = 0; ID_payload_IN = 0; IQ_full_IN = 0;
    LSQ_full_IN = 0; ROB_full_IN = 0; RET_freeReq_IN = 0; RET_freeReg_IN = 0;
  endtask
  task automatic drive(input int s1, input int s2, input int d, input bit need, input bit mem);
    idle();
    ID_valid_IN = 1; ID_src1_IN = 5'(s1); ID_src2_IN = 5'(s2); ID_dest_IN = 5'(d);
    ID_needDest_IN = need; ID_isMem_IN = mem; ID_payload_IN = {$urandom, $urandom};
  endtask
  task automatic step();
    bit eff, st, acc;
    int d, o, p1, p2;
    #1;
    eff = ID_needDest_IN && ID_dest_IN != 0;
    st = FREEZE || ROB_full_IN || (eff && fl.size() == 0) ||
         (ID_isMem_IN ? (LSQ_full_IN || mlsq) : (IQ_full_IN || miq));
    chk("stall", ID_stall_OUT, st);
    acc = ID_valid_IN && !st;
    if (!RESET) mreset();
    else begin
      if (acc) begin
        d = 0; o = 0;
        p1 = mmap[ID_src1_IN]; p2 = mmap[ID_src2_IN];
        if (eff) begin
          d = fl.pop_front();
          o = mmap[ID_dest_IN];
          mmap[ID_dest_IN] = d;
        end
        mdata = {ID_payload_IN, 6'(mrob), 6'(o), 6'(d), 6'(p2), 6'(p1), eff};
        mrob = (mrob + 1) % 64;
      end
      miq = acc && !ID_isMem_IN;
      mlsq = acc && ID_isMem_IN;
      if (RET_freeReq_IN) begin
        if (fl.size() < 32) fl.push_back(int'(RET_freeReg_IN));
        else movf = 1;
      end
    end
    @(posedge CLK);
    #1;
    chk("iq_push", IQ_pushReq_OUT, miq);
    chk("lsq_push", LSQ_pushReq_OUT, mlsq);
    chk("push_data", REN_pushData_OUT, mdata);
    chk("overflow", FL_overflow_OUT, movf);
  endtask
  task automatic do_reset();
    idle(); RESET = 0; step(); step(); RESET = 1;
  endtask
  initial begin
    RESET = 1; idle(); mreset();
    @(posedge CLK); #1;
    do_reset();
    chk("rst_iq", IQ_pushReq_OUT, 0);
    chk("rst_lsq", LSQ_pushReq_OUT, 0);
    chk("rst_data", REN_pushData_OUT, 0);
    chk("rst_ovf", FL_overflow_OUT, 0);
    drive(5, 3, 5, 1, 0); step();
    chk("first_iq", IQ_pushReq_OUT, 1);
    chk("first_src1", REN_pushData_OUT[6:1], 5);
    chk("first_src2", REN_pushData_OUT[12:7], 3);
    chk("first_dest", REN_pushData_OUT[18:13], 32);
    chk("first_old", REN_pushData_OUT[24:19], 5);
    chk("first_rob", REN_pushData_OUT[30:25], 0);
    drive(5, 0, 0, 0, 1); step();
    chk("remap_src1", REN_pushData_OUT[6:1], 32);
    for (int k = 0; k < 31; k++) begin
      drive(1, 2, k + 1, 1, k[0]); step();
      chk("exh_dest", REN_pushData_OUT[18:13], 128'(33 + k));
    end
    drive(1, 2, 9, 1, 1); RET_freeReq_IN = 1; RET_freeReg_IN = 7;
    #1 chk("empty_stall", ID_stall_OUT, 1);
    step();
    RET_freeReq_IN = 0; step();
    chk("refill_lsq", LSQ_pushReq_OUT, 1);
    chk("refill_dest", REN_pushData_OUT[18:13], 7);
    idle(); step();
    drive(2, 3, 0, 1, 1); step();
    chk("r0_lsq", LSQ_pushReq_OUT, 1);
    chk("r0_dest", REN_pushData_OUT[18:13], 0);
    chk("r0_old", REN_pushData_OUT[24:19], 0);
    idle(); step();
    drive(1, 1, 0, 0, 1); LSQ_full_IN = 1;
    #1 chk("lsqfull_stall", ID_stall_OUT, 1);
    ID_isMem_IN = 0; step();
    chk("swap_iq", IQ_pushReq_OUT, 1);
    chk("swap_rob", REN_pushData_OUT[30:25], 35);
    do_reset();
    for (int i = 0; i < 65; i++) begin
      drive(0, 0, 0, 0, i[0]); step();
      chk("rob_seq", REN_pushData_OUT[30:25], 128'(i % 64));
    end
    do_reset();
    idle(); RET_freeReq_IN = 1; RET_freeReg_IN = 9; step();
    chk("ovf_set", FL_overflow_OUT, 1);
    idle(); repeat (3) step();
    chk("ovf_sticky", FL_overflow_OUT, 1);
    drive(4, 4, 4, 1, 0); RESET = 0; step();
    chk("mid_rst_iq", IQ_pushReq_OUT, 0);
    chk("mid_rst_ovf", FL_overflow_OUT, 0);
    RESET = 1; drive(5, 0, 0, 0, 0); step();
    chk("mid_rst_map", REN_pushData_OUT[6:1], 5);
    for (int c = 0; c < 4000; c++) begin
      idle();
      RESET = $urandom_range(0, 199) != 0;
      FREEZE = $urandom_range(0, 15) == 0;
      ROB_full_IN = $urandom_range(0, 15) == 0;
      IQ_full_IN = $urandom_range(0, 7) == 0;
      LSQ_full_IN = $urandom_range(0, 7) == 0;
      ID_valid_IN = $urandom_range(0, 3) != 0;
      ID_src1_IN = 5'($urandom); ID_src2_IN = 5'($urandom); ID_dest_IN = 5'($urandom);
      ID_needDest_IN = $urandom_range(0, 3) != 0;
      ID_isMem_IN = 1'($urandom);
      ID_payload_IN = {$urandom, $urandom};
      RET_freeReq_IN = ((c / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      RET_freeReg_IN = 6'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
